vga_sprite_engine: RTL and testbench

VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

---
 rtl/vga_sprite_engine.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine
//   Renders one frame per falling edge of iVSync into a pixel-write stream:
//   a full-screen background copied from a background ROM, an optional row of
//   decimal score digits taken from a digit sprite ROM, and a small square
//   mouse cursor. Every pixel takes one cycle; both ROMs have 1-cycle read
//   latency, so each write appears on oX/oY/oColor/oWriteEn one cycle after
//   the address that produced it.
//
// Ports
//   clk, iResetn         clock, asynchronous active-low reset
//   iVSync               falling edge (while idle) starts a frame
//   iScreenSel           screen select, latched at frame start
//   iScore               score, latched at frame start
//   iMouseX, iMouseY     cursor position, latched at frame start
//   oBgAddr / iBgData    background ROM address / data
//   oSprAddr, oSprDigit  digit ROM pixel address and digit select
//   iSprData             digit ROM data
//   oX, oY, oColor       pixel being written
//   oWriteEn             pixel write strobe
//   oBusy                frame in progress (BG, DIGITS, CURSOR)
//   oFrameDone           one-cycle pulse at frame end
module vga_sprite_engine #(
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240,
    parameter int COLOR_W      = 3,
    parameter int NUM_DIGITS   = 4,
    parameter int SCORE_W      = 14,
    parameter int SPR_W        = 18,
    parameter int SPR_H        = 18,
    parameter int DIGIT_X0     = 120,
    parameter int DIGIT_Y0     = 155,
    parameter int DIGIT_PITCH  = 17,
    parameter int CURSOR_SZ    = 4,
    parameter int CURSOR_COLOR = 0,
    parameter int TKEY         = 7,
    parameter int LZ_BLANK     = 1,
    parameter int SCORE_SCREEN = 3
) (
    input  logic               clk,
    input  logic               iResetn,
    input  logic               iVSync,
    input  logic [1:0]         iScreenSel,
    input  logic [SCORE_W-1:0] iScore,
    input  logic [8:0]         iMouseX,
    input  logic [7:0]         iMouseY,
    output logic [16:0]        oBgAddr,
    input  logic [COLOR_W-1:0] iBgData,
    output logic [9:0]         oSprAddr,
    output logic [3:0]         oSprDigit,
    input  logic [COLOR_W-1:0] iSprData,
    output logic [8:0]         oX,
    output logic [7:0]         oY,
    output logic [COLOR_W-1:0] oColor,
    output logic               oWriteEn,
    output logic               oBusy,
    output logic               oFrameDone
);

    localparam int          BG_LAST   = SCREEN_W * SCREEN_H - 1;
    localparam int          SPR_LAST  = SPR_W * SPR_H - 1;
    localparam int          DIG_IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SCORE_MAX = 10 ** NUM_DIGITS - 1;

    typedef enum logic [2:0] {IDLE, BG, DIGITS, CURSOR, DONE} state_t;
    typedef enum logic [1:0] {SRC_BG, SRC_SPR, SRC_CUR} src_t;

    state_t state, state_nxt;

    // Frame-start capture
    logic                  vs_q;
    logic                  vs_fall;
    logic [1:0]            screen_q;
    logic [8:0]            mouse_x_q;
    logic [7:0]            mouse_y_q;
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_q;

    // Pixel scan counters
    logic [16:0]       bg_addr;
    logic [8:0]        bg_x;
    logic [7:0]        bg_y;
    logic [9:0]        spr_addr;
    logic [8:0]        spr_col;
    logic [7:0]        spr_row;
    logic [DIG_IW-1:0] dig_idx;
    logic [9:0]        dig_x0;
    logic [8:0]        cur_col;
    logic [7:0]        cur_row;

    // Write pipeline stage (aligned with ROM data)
    logic       pend_valid;
    src_t       pend_src;
    logic [8:0] pend_x;
    logic [7:0] pend_y;

    logic bg_last, spr_last, dig_last, cur_last;

    // Coordinates one bit wider than the outputs; the MSB is the sign.
    logic [9:0] spr_px, cur_px;
    logic [8:0] spr_py, cur_py;
    logic       spr_in, cur_in;

    // Saturated score split into decimal digits, MS first, plus leading-zero mask
    logic [3:0]            digit_c [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_c;

    always_comb begin : split_score
        int unsigned s;
        logic        lead;
        digit_c = '{default: '0};
        blank_c = '0;
        s       = 32'(iScore);
        if (s > SCORE_MAX) s = SCORE_MAX;
        lead = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            digit_c[k] = 4'((s / (10 ** (NUM_DIGITS - 1 - k))) % 10);
            if (digit_c[k] != 4'd0) lead = 1'b0;
            blank_c[k] = (LZ_BLANK != 0) && lead && (k != NUM_DIGITS - 1);
        end
    end

    assign vs_fall  = vs_q & ~iVSync;
    assign bg_last  = (bg_addr == 17'(BG_LAST));
    assign spr_last = (spr_addr == 10'(SPR_LAST));
    assign dig_last = (dig_idx == DIG_IW'(NUM_DIGITS - 1));
    assign cur_last = (cur_col == 9'(CURSOR_SZ - 1)) && (cur_row == 8'(CURSOR_SZ - 1));

    assign spr_px = dig_x0 + {1'b0, spr_col};
    assign spr_py = 9'(DIGIT_Y0) + {1'b0, spr_row};
    assign spr_in = !spr_px[9] && (spr_px < 10'(SCREEN_W)) &&
                    !spr_py[8] && (spr_py < 9'(SCREEN_H));

    assign cur_px = {1'b0, mouse_x_q} + {1'b0, cur_col} - 10'd1;
    assign cur_py = {1'b0, mouse_y_q} + {1'b0, cur_row} - 9'd1;
    assign cur_in = !cur_px[9] && (cur_px < 10'(SCREEN_W)) &&
                    !cur_py[8] && (cur_py < 9'(SCREEN_H));

    // State register
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        oBusy      = 1'b0;
        oFrameDone = 1'b0;
        oSprDigit  = '0;
        case (state)
            IDLE: begin
                if (vs_fall) state_nxt = BG;
            end
            BG: begin
                oBusy = 1'b1;
                if (bg_last)
                    state_nxt = (screen_q == 2'(SCORE_SCREEN)) ? DIGITS : CURSOR;
            end
            DIGITS: begin
                oBusy     = 1'b1;
                oSprDigit = digit_q[dig_idx];
                if (spr_last && dig_last) state_nxt = CURSOR;
            end
            CURSOR: begin
                oBusy = 1'b1;
                if (cur_last) state_nxt = DONE;
            end
            DONE: begin
                oFrameDone = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, scan counters, write pipeline.
    // Each state returns its counters to zero on its last pixel, so the
    // next frame (or an aborted one after reset) always starts from zero.
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            vs_q       <= 1'b1;
            screen_q   <= '0;
            mouse_x_q  <= '0;
            mouse_y_q  <= '0;
            digit_q    <= '{default: '0};
            blank_q    <= '0;
            bg_addr    <= '0;
            bg_x       <= '0;
            bg_y       <= '0;
            spr_addr   <= '0;
            spr_col    <= '0;
            spr_row    <= '0;
            dig_idx    <= '0;
            dig_x0     <= '0;
            cur_col    <= '0;
            cur_row    <= '0;
            pend_valid <= 1'b0;
            pend_src   <= SRC_BG;
            pend_x     <= '0;
            pend_y     <= '0;
        end else begin
            vs_q       <= iVSync;
            pend_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_fall) begin
                        screen_q  <= iScreenSel;
                        mouse_x_q <= iMouseX;
                        mouse_y_q <= iMouseY;
                        digit_q   <= digit_c;
                        blank_q   <= blank_c;
                        dig_x0    <= 10'(DIGIT_X0);
                    end
                end
                BG: begin
                    pend_valid <= 1'b1;
                    pend_src   <= SRC_BG;
                    pend_x     <= bg_x;
                    pend_y     <= bg_y;
                    if (bg_last) begin
                        bg_addr <= '0;
                        bg_x    <= '0;
                        bg_y    <= '0;
                    end else begin
                        bg_addr <= bg_addr + 17'd1;
                        if (bg_x == 9'(SCREEN_W - 1)) begin
                            bg_x <= '0;
                            bg_y <= bg_y + 8'd1;
                        end else begin
                            bg_x <= bg_x + 9'd1;
                        end
                    end
                end
                DIGITS: begin
                    // Blanked digits still scan their sprite but never write.
                    pend_valid <= !blank_q[dig_idx] && spr_in;
                    pend_src   <= SRC_SPR;
                    pend_x     <= spr_px[8:0];
                    pend_y     <= spr_py[7:0];
                    if (spr_last) begin
                        spr_addr <= '0;
                        spr_col  <= '0;
                        spr_row  <= '0;
                        dig_x0   <= dig_x0 + 10'(DIGIT_PITCH);
                        dig_idx  <= dig_last ? '0 : dig_idx + DIG_IW'(1);
                    end else begin
                        spr_addr <= spr_addr + 10'd1;
                        if (spr_col == 9'(SPR_W - 1)) begin
                            spr_col <= '0;
                            spr_row <= spr_row + 8'd1;
                        end else begin
                            spr_col <= spr_col + 9'd1;
                        end
                    end
                end
                CURSOR: begin
                    pend_valid <= cur_in;
                    pend_src   <= SRC_CUR;
                    pend_x     <= cur_px[8:0];
                    pend_y     <= cur_py[7:0];
                    if (cur_col == 9'(CURSOR_SZ - 1)) begin
                        cur_col <= '0;
                        cur_row <= cur_last ? '0 : cur_row + 8'd1;
                    end else begin
                        cur_col <= cur_col + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ROM data arrives with the pending write, so colour and the
    // transparency test are taken combinationally from the ROM outputs.
    always_comb begin
        oColor = '0;
        if (pend_valid) begin
            case (pend_src)
                SRC_BG:  oColor = iBgData;
                SRC_SPR: oColor = iSprData;
                default: oColor = COLOR_W'(CURSOR_COLOR);
            endcase
        end
    end

    assign oWriteEn = pend_valid && !((pend_src == SRC_SPR) && (iSprData == COLOR_W'(TKEY)));
    assign oBgAddr  = bg_addr;
    assign oSprAddr = spr_addr;
    assign oX       = pend_x;
    assign oY       = pend_y;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Testbench for vga_sprite_engine, built on a reduced 40x30 screen with 4x3
// digit sprites so that many full frames fit in a short run. Background and
// digit ROMs are modelled with 1-cycle latency; every write is captured and
// compared against a frame list built independently from the requirements.
module tb_vga_sprite_engine;

    localparam int W   = 40;
    localparam int H   = 30;
    localparam int SW  = 4;
    localparam int SH  = 3;
    localparam int X0  = 6;
    localparam int Y0  = 12;
    localparam int P   = 5;
    localparam int CSZ = 4;

    logic        clk = 1'b0;
    logic        iResetn = 1'b0;
    logic        iVSync = 1'b1;
    logic [1:0]  iScreenSel = '0;
    logic [13:0] iScore = '0;
    logic [8:0]  iMouseX = '0;
    logic [7:0]  iMouseY = '0;
    logic [16:0] oBgAddr;
    logic [2:0]  iBgData = '0;
    logic [9:0]  oSprAddr;
    logic [3:0]  oSprDigit;
    logic [2:0]  iSprData = '0;
    logic [8:0]  oX;
    logic [7:0]  oY;
    logic [2:0]  oColor;
    logic        oWriteEn, oBusy, oFrameDone;

    always #5 clk = ~clk;

    vga_sprite_engine #(
        .SCREEN_W(W), .SCREEN_H(H), .SPR_W(SW), .SPR_H(SH),
        .DIGIT_X0(X0), .DIGIT_Y0(Y0), .DIGIT_PITCH(P)
    ) dut (
        .clk(clk), .iResetn(iResetn), .iVSync(iVSync), .iScreenSel(iScreenSel),
        .iScore(iScore), .iMouseX(iMouseX), .iMouseY(iMouseY),
        .oBgAddr(oBgAddr), .iBgData(iBgData), .oSprAddr(oSprAddr),
        .oSprDigit(oSprDigit), .iSprData(iSprData), .oX(oX), .oY(oY),
        .oColor(oColor), .oWriteEn(oWriteEn), .oBusy(oBusy), .oFrameDone(oFrameDone)
    );

    function automatic logic [2:0] bg_rom(input int a);
        return 3'((a ^ (a >> 3)) & 7);
    endfunction

    function automatic logic [2:0] spr_rom(input int d, input int a);
        return 3'((d * 5 + a) & 7);
    endfunction

    always @(posedge clk) begin
        iBgData  <= bg_rom(int'(oBgAddr));
        iSprData <= spr_rom(int'(oSprDigit), int'(oSprAddr));
    end

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    px_t got_q[$];
    px_t exp_q[$];
    px_t mon_p;
    int  busy_cyc = 0;
    int  done_cnt = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    always @(negedge clk) begin
        if (oWriteEn === 1'b1) begin
            mon_p.x = int'(oX);
            mon_p.y = int'(oY);
            mon_p.c = int'(oColor);
            got_q.push_back(mon_p);
        end
        if (oBusy === 1'b1) busy_cyc++;
        if (oFrameDone === 1'b1) done_cnt++;
    end

    // Reference frame: background, optional digits, clipped cursor.
    function automatic void build_exp(input int scr, input int sc, input int mx, input int my);
        int  s, d, lead, blank, v, x, y;
        px_t p;
        exp_q.delete();
        for (int i = 0; i < W * H; i++) begin
            p.x = i % W; p.y = i / W; p.c = int'(bg_rom(i));
            exp_q.push_back(p);
        end
        if (scr == 3) begin
            s    = (sc > 9999) ? 9999 : sc;
            lead = 1;
            for (int k = 0; k < 4; k++) begin
                d = (k == 0) ? s / 1000 : (k == 1) ? (s / 100) % 10 :
                    (k == 2) ? (s / 10) % 10 : s % 10;
                if (d != 0) lead = 0;
                blank = (lead != 0 && k != 3) ? 1 : 0;
                for (int r = 0; r < SH; r++)
                    for (int c = 0; c < SW; c++) begin
                        v = int'(spr_rom(d, r * SW + c));
                        if (blank == 0 && v != 7) begin
                            p.x = X0 + k * P + c; p.y = Y0 + r; p.c = v;
                            exp_q.push_back(p);
                        end
                    end
            end
        end
        for (int r = 0; r < CSZ; r++)
            for (int c = 0; c < CSZ; c++) begin
                x = mx - 1 + c;
                y = my - 1 + r;
                if (x >= 0 && x < W && y >= 0 && y < H) begin
                    p.x = x; p.y = y; p.c = 0;
                    exp_q.push_back(p);
                end
            end
    endfunction

    // Index of the first differing write, or -1 when the lists are identical.
    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].c != exp_q[i].c)
                return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        busy_cyc = 0;
        done_cnt = 0;
    endtask

    task automatic start_frame(input int scr, input int sc, input int mx, input int my);
        iScreenSel = 2'(scr);
        iScore     = 14'(sc);
        iMouseX    = 9'(mx);
        iMouseY    = 8'(my);
        iVSync     = 1'b1;
        repeat (2) @(negedge clk);
        iVSync = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (oFrameDone === 1'b1) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [53:0] outs;
        repeat (3) @(negedge clk);
        outs = {oBgAddr, oSprAddr, oSprDigit, oX, oY, oColor, oWriteEn, oBusy, oFrameDone};
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
        iResetn = 1'b1;
        clear_mon();
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy_cyc !== 0) begin n_bad++; $display("FAIL idle_no_start: busy %0d want 0", busy_cyc); end
        n_cmp++;
        if (got_q.size() !== 0) begin n_bad++; $display("FAIL idle_no_write: writes %0d want 0", got_q.size()); end
    endtask

    task automatic test_menu_frame();
        int ok, fd;
        clear_mon();
        build_exp(0, 0, 10, 20);
        start_frame(0, 0, 10, 20);
        wait_done(W * H + 200, ok);
        fd = first_diff();
        n_cmp++;
        if (ok !== 1) begin n_bad++; $display("FAIL menu_timeout: done seen %0d want 1", ok); end
        n_cmp++;
        if (got_q.size() !== W * H + 16) begin n_bad++; $display("FAIL menu_writes: got %0d want %0d", got_q.size(), W * H + 16); end
        n_cmp++;
        if (fd !== -1) begin n_bad++; $display("FAIL menu_pixels: first diff at %0d want -1", fd); end
        n_cmp++;
        if (busy_cyc !== W * H + 16) begin n_bad++; $display("FAIL menu_busy: got %0d want %0d", busy_cyc, W * H + 16); end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL menu_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_score_frame();
        int ok, fd;
        int scores[4] = '{405, 12345, 0, 1000};
        for (int t = 0; t < 4; t++) begin
            clear_mon();
            build_exp(3, scores[t], 20, 5);
            start_frame(3, scores[t], 20, 5);
            wait_done(W * H + 4 * SW * SH + 200, ok);
            fd = first_diff();
            n_cmp++;
            if (ok !== 1) begin n_bad++; $display("FAIL score_timeout[%0d]: done seen %0d want 1", scores[t], ok); end
            n_cmp++;
            if (fd !== -1) begin n_bad++; $display("FAIL score_pixels[%0d]: first diff at %0d want -1", scores[t], fd); end
            n_cmp++;
            if (busy_cyc !== W * H + 4 * SW * SH + 16) begin
                n_bad++; $display("FAIL score_busy[%0d]: got %0d want %0d", scores[t], busy_cyc, W * H + 4 * SW * SH + 16);
            end
        end
        // score 405: digit 4 at x=11 row 0 writes colours 4,5,6 (col 3 is transparent)
        clear_mon();
        start_frame(3, 405, 20, 5);
        wait_done(W * H + 4 * SW * SH + 200, ok);
        n_cmp++;
        if (got_q.size() < W * H + 3 || got_q[W * H].x !== 11 || got_q[W * H].y !== 12 || got_q[W * H].c !== 4) begin
            n_bad++; $display("FAIL score_first_digit_px: size %0d want first digit write (11,12,4)", got_q.size());
        end
        n_cmp++;
        if (got_q.size() < W * H + 4 || got_q[W * H + 3].x !== 11 || got_q[W * H + 3].y !== 13) begin
            n_bad++; $display("FAIL score_tkey_skip: size %0d want 4th digit write at (11,13)", got_q.size());
        end
    endtask

    task automatic test_clipping();
        int ok, fd;
        int mxs[2] = '{0, 39};
        int mys[2] = '{0, 29};
        int ncur[2] = '{9, 4};
        for (int t = 0; t < 2; t++) begin
            clear_mon();
            build_exp(0, 0, mxs[t], mys[t]);
            start_frame(0, 0, mxs[t], mys[t]);
            wait_done(W * H + 200, ok);
            fd = first_diff();
            n_cmp++;
            if (got_q.size() - W * H !== ncur[t]) begin
                n_bad++; $display("FAIL clip_count[%0d]: got %0d want %0d", t, got_q.size() - W * H, ncur[t]);
            end
            n_cmp++;
            if (fd !== -1) begin n_bad++; $display("FAIL clip_pixels[%0d]: first diff at %0d want -1", t, fd); end
            n_cmp++;
            if (busy_cyc !== W * H + 16) begin n_bad++; $display("FAIL clip_busy[%0d]: got %0d want %0d", t, busy_cyc, W * H + 16); end
        end
    endtask

    task automatic test_vsync_ignored();
        int ok, fd, hold;
        clear_mon();
        build_exp(3, 405, 10, 10);
        start_frame(3, 405, 10, 10);
        for (int i = 0; i < W * H + 100 && busy_cyc < W * H + 6; i++) @(negedge clk);
        iVSync = 1'b1;
        @(negedge clk);
        iVSync = 1'b0;
        wait_done(W * H + 200, ok);
        fd = first_diff();
        n_cmp++;
        if (busy_cyc !== W * H + 4 * SW * SH + 16) begin
            n_bad++; $display("FAIL vs_ignore_busy: got %0d want %0d", busy_cyc, W * H + 4 * SW * SH + 16);
        end
        n_cmp++;
        if (fd !== -1) begin n_bad++; $display("FAIL vs_ignore_pixels: first diff at %0d want -1", fd); end
        hold = busy_cyc;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy_cyc !== hold || done_cnt !== 1) begin
            n_bad++; $display("FAIL vs_ignore_restart: busy %0d done %0d want %0d and 1", busy_cyc, done_cnt, hold);
        end
    endtask

    task automatic test_reset_midframe();
        int ok, fd;
        logic [30:0] outs;
        clear_mon();
        start_frame(0, 0, 5, 5);
        repeat (100) @(negedge clk);
        #2 iResetn = 1'b0;
        #1 outs = {oBgAddr, oX, oWriteEn, oBusy, oFrameDone, oColor};
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL async_reset_outputs: got %h want 0", outs); end
        iVSync = 1'b1;
        repeat (4) @(negedge clk);
        iResetn = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        clear_mon();
        build_exp(0, 0, 5, 5);
        start_frame(0, 0, 5, 5);
        wait_done(W * H + 200, ok);
        fd = first_diff();
        n_cmp++;
        if (fd !== -1) begin n_bad++; $display("FAIL restart_pixels: first diff at %0d want -1", fd); end
        n_cmp++;
        if (done_cnt !== 1 || busy_cyc !== W * H + 16) begin
            n_bad++; $display("FAIL restart_frame: done %0d busy %0d want 1 and %0d", done_cnt, busy_cyc, W * H + 16);
        end
    endtask

    initial begin
        test_reset();
        test_menu_frame();
        test_score_frame();
        test_clipping();
        test_vsync_ignored();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
